leaf_rx_stream_demux: RTL
=========================

// Module: leaf_rx_stream_demux
// PURPOSE
//   Input half of a leaf interface. Sits between the BFT leaf port (din_leaf_bft2interface) and the operator
//   inside a DFX page. Accepts 49-bit BFT packets with no backpressure, filters them by leaf address, and demuxes
//   them by port field into per-port FIFOs. Drives valid/ready streams to the operator and counts dropped packets.
// PARAMETERS
//   NUM_PORTS   2      number of operator input streams (1..8)
//   FIFO_DEPTH  16     entries per port FIFO; power of two, >=2
//   LEAF_ADDR   5'd2   this leaf's BFT address; packets addressed elsewhere are dropped
// PORTS
//   clk                     in   1              page clock
//   reset                   in   1              async, active-high
//   ap_start                in   1              level; enables packet intake
//   resend                  in   1              one-cycle pulse; flushes all FIFOs
//   din_leaf_bft2interface  in   49             [48] vld, [47:43] dst leaf, [42:40] port, [39:32] rsvd, [31:0] data
//   out_data                out  NUM_PORTS*32   port p data at [32p+31:32p]
//   out_valid               out  NUM_PORTS      per-port valid
//   out_ready               in   NUM_PORTS      per-port ready from operator
//   overflow_cnt            out  16             packets dropped on a full FIFO; saturates at 16'hFFFF
//   misroute_cnt            out  16             packets dropped for wrong leaf or port>=NUM_PORTS; saturates
//   busy                    out  1              any FIFO non-empty
// BEHAVIOUR
//   Reset (async assert, sync deassert in use):
//     - FSM=IDLE; all FIFOs empty; out_valid=0, out_data=0, counters=0, busy=0.
//   FSM:
//     - IDLE -> RUN when ap_start=1. In IDLE, incoming packets are ignored and not counted.
//     - RUN -> FLUSH on resend=1. FLUSH lasts exactly 1 cycle: all FIFO pointers and counts cleared,
//       out_valid=0, input packet in that cycle discarded. Then FLUSH -> RUN.
//     - RUN -> IDLE when ap_start=0 and all FIFOs are empty. FIFOs still drain while ap_start=0.
//     - resend in IDLE also clears FIFOs and stays IDLE. Counters are cleared only by reset.
//   Intake (RUN only, din[48]=1):
//     - If dst!=LEAF_ADDR or port>=NUM_PORTS: drop, misroute_cnt++.
//     - Else if FIFO[port] occupancy<FIFO_DEPTH, or that FIFO pops in the same cycle: write din[31:0].
//     - Else: drop, overflow_cnt++.
//     - At most one packet per cycle; din[48]=0 is a no-op.
//   Output:
//     - FIFO head is registered (first-word fall-through). A packet written at edge t is visible with out_valid=1
//       after edge t, i.e. 1-cycle latency into an empty FIFO.
//     - Transfer occurs when out_valid[p]&out_ready[p]. out_data[p] is held stable while valid&!ready.
//     - Ports are fully independent; ready is never required for another port's progress.
//   Arithmetic:
//     - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; occupancy is log2(FIFO_DEPTH)+1 bits.
//     - Counters saturate at 16'hFFFF and never wrap.
//     - Simultaneous push+pop on a non-empty FIFO leaves occupancy unchanged.
//   Mid-operation:
//     - Reset during any state returns to IDLE in the same cycle; in-flight data is lost.
//     - resend coincident with a push or pop: flush wins; no transfer is reported.
// TESTING
//   1. reset, ap_start=1, send {1,5'd2,3'd0,8'd0,32'hDEADBEEF}, out_ready=1
//      -> out_valid[0]=1 with out_data[31:0]=DEADBEEF one cycle later, for exactly 1 cycle.
//   2. out_ready=0, send 17 packets to port 1 (data 1..17)
//      -> 16 stored, overflow_cnt=1; on ready=1, data 1..16 drains in order; busy falls after the last.
//   3. Full port-0 FIFO with out_ready[0]=1, push in the same cycle
//      -> accepted, overflow_cnt unchanged, occupancy stays 16.
//   4. Packets with dst=5'd3 and with port=3'd2 (NUM_PORTS=2)
//      -> misroute_cnt=2, no out_valid; 70000 misroutes -> misroute_cnt=16'hFFFF.
//   5. FIFOs holding 5 and 3 entries, pulse resend with a valid packet on din
//      -> next cycle out_valid=0, busy=0; the packet is discarded; the following packet is delivered normally.
//   6. ap_start=0 while data is pending
//      -> remaining data drains, FSM returns to IDLE; new packets are ignored and no counter changes;
//      reset asserted mid-stream clears all outputs asynchronously.

Source files
------------

// File: rtl/leaf_rx_stream_demux.sv
// Leaf interface input half: filters BFT packets by leaf address and demuxes them by port
// into per-port first-word-fall-through FIFOs with valid/ready outputs and drop counters.
module leaf_rx_stream_demux #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [4:0]  LEAF_ADDR  = 5'd2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ap_start,
    input  logic                    resend,
    input  logic [48:0]             din_leaf_bft2interface,
    output logic [NUM_PORTS*32-1:0] out_data,
    output logic [NUM_PORTS-1:0]    out_valid,
    input  logic [NUM_PORTS-1:0]    out_ready,
    output logic [15:0]             overflow_cnt,
    output logic [15:0]             misroute_cnt,
    output logic                    busy
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);
    localparam logic [3:0] NumPortsC = 4'(NUM_PORTS);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e state_q, state_d;

    logic [PtrW-1:0] wr_ptr_q [NUM_PORTS];
    logic [PtrW-1:0] wr_ptr_d [NUM_PORTS];
    logic [PtrW-1:0] rd_ptr_q [NUM_PORTS];
    logic [PtrW-1:0] rd_ptr_d [NUM_PORTS];
    logic [CntW-1:0] cnt_q [NUM_PORTS];
    logic [CntW-1:0] cnt_d [NUM_PORTS];
    logic [31:0]     mem_q [NUM_PORTS][FIFO_DEPTH];
    logic [31:0]     mem_d [NUM_PORTS][FIFO_DEPTH];

    logic [15:0] ovf_q, ovf_d;
    logic [15:0] mis_q, mis_d;

    logic                 pkt_vld;
    logic [4:0]           pkt_dst;
    logic [2:0]           pkt_port;
    logic [31:0]          pkt_data;
    logic                 addr_ok;
    logic                 intake;
    logic                 clear_fifos;
    logic                 all_empty;
    logic                 ovf_hit;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] sel;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] push;
    logic                 unused_rsvd;

    assign pkt_vld     = din_leaf_bft2interface[48];
    assign pkt_dst     = din_leaf_bft2interface[47:43];
    assign pkt_port    = din_leaf_bft2interface[42:40];
    assign pkt_data    = din_leaf_bft2interface[31:0];
    assign unused_rsvd = ^din_leaf_bft2interface[39:32];

    assign addr_ok     = (pkt_dst == LEAF_ADDR) && ({1'b0, pkt_port} < NumPortsC);
    // A resend cycle and the following flush cycle both discard input and hide the FIFO heads.
    assign clear_fifos = resend || (state_q == StFlush);
    assign intake      = (state_q == StRun) && !resend && pkt_vld;

    assign overflow_cnt = ovf_q;
    assign misroute_cnt = mis_q;

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        full      = '0;
        sel       = '0;
        pop       = '0;
        push      = '0;
        all_empty = 1'b1;
        ovf_hit   = 1'b0;
        mem_d     = mem_q;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            wr_ptr_d[p] = wr_ptr_q[p];
            rd_ptr_d[p] = rd_ptr_q[p];
            cnt_d[p]    = cnt_q[p];

            full[p]      = (cnt_q[p] == DepthC);
            sel[p]       = (pkt_port == 3'(p));
            out_valid[p] = (cnt_q[p] != '0) && !clear_fifos;
            pop[p]       = out_valid[p] && out_ready[p];
            push[p]      = intake && addr_ok && sel[p] && (!full[p] || pop[p]);
            if (intake && addr_ok && sel[p] && full[p] && !pop[p]) begin
                ovf_hit = 1'b1;
            end
            if (cnt_q[p] != '0) begin
                all_empty = 1'b0;
            end
            if (out_valid[p]) begin
                out_data[32*p +: 32] = mem_q[p][rd_ptr_q[p]];
            end

            if (clear_fifos) begin
                wr_ptr_d[p] = '0;
                rd_ptr_d[p] = '0;
                cnt_d[p]    = '0;
            end else begin
                if (push[p]) begin
                    mem_d[p][wr_ptr_q[p]] = pkt_data;
                    wr_ptr_d[p] = wr_ptr_q[p] + PtrW'(1);
                end
                if (pop[p]) begin
                    rd_ptr_d[p] = rd_ptr_q[p] + PtrW'(1);
                end
                cnt_d[p] = cnt_q[p] + CntW'(push[p]) - CntW'(pop[p]);
            end
        end
        busy = !all_empty;
    end

    always_comb begin
        ovf_d = ovf_q;
        mis_d = mis_q;
        if (ovf_hit && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
        if (intake && !addr_ok && (mis_q != 16'hFFFF)) begin
            mis_d = mis_q + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!resend && ap_start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (resend) begin
                    state_d = StFlush;
                end else if (!ap_start && all_empty) begin
                    state_d = StIdle;
                end
            end
            StFlush: state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ovf_q   <= '0;
            mis_q   <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                cnt_q[p]    <= '0;
            end
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            mis_q   <= mis_d;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                wr_ptr_q[p] <= wr_ptr_d[p];
                rd_ptr_q[p] <= rd_ptr_d[p];
                cnt_q[p]    <= cnt_d[p];
            end
        end
    end

    // Storage needs no reset: heads are only visible while the occupancy is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
